sa_weight_addr_gen: RTL
=======================

// Module: sa_weight_addr_gen
// PURPOSE
//  Sequential weight-address generator for the systolic array (SA) weight buffer.
//  Replaces the fixed 3x3 count-to-address lookup with a parametrised DIMxDIM walker.
//  Walks the matrix in linear (row-major) or transposed (column-major) order from a
//  programmable base and streams addresses to the weight SRAM reader over valid/ready.
// PARAMETERS
//  DIM     3  matrix edge; DIM*DIM addresses per matrix; range 2..16
//  ADDR_W  6  address width; base+offset arithmetic wraps modulo 2^ADDR_W
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       one-cycle request; sampled only in IDLE
//  transpose   in   1       1: column-major walk; 0: row-major; latched on start
//  base_addr   in   ADDR_W  matrix base address; latched on start
//  addr_valid  out  1       addr holds a valid weight address
//  addr_ready  in   1       consumer accepts addr when addr_valid&&addr_ready
//  addr        out  ADDR_W  current weight address
//  addr_last   out  1       high with the final address of the walk
//  busy        out  1       high in RUN
//  done        out  1       one-cycle pulse after the final handshake
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; row/col counters 0; latched mode/base 0.
//  - FSM IDLE -> RUN on start; RUN -> DONE on handshake of addr_last; DONE -> IDLE
//    unconditionally (done=1 only in DONE). start in RUN/DONE is ignored.
//  - Latency: start at cycle t -> addr_valid=1 with first address (base) at t+1.
//  - Walk uses outer index o and inner index i, each 0..DIM-1; i advances per
//    handshake, wraps to 0 and advances o. Offset = transpose ? i*DIM+o : o*DIM+i.
//    DIM=3 transposed offsets: 0,3,6,1,4,7,2,5,8.
//  - No multiplier: running address register; inner step adds (transpose?DIM:1);
//    inner wrap reloads base+(o+1)*(transpose?1:DIM) from an outer-base register.
//  - addr, addr_last stable while addr_valid&&!addr_ready; advance only on handshake.
//  - Back-to-back: one address per cycle with addr_ready held high; DIM*DIM cycles.
//  - addr_last = (o==DIM-1)&&(i==DIM-1)&&addr_valid.
//  - base+offset overflow wraps modulo 2^ADDR_W; no error flag.
//  - In DONE, addr_valid=0; next start accepted once back in IDLE (2 cycles after
//    last handshake at the earliest).
//  - Reset mid-walk: immediate return to IDLE, addr_valid=0, no done pulse.
// CONFIGURATION
//  SA_WADDR_TILE_EN defined: adds input num_tiles[3:0] (latched on start, 0 treated
//    as 1); walk repeats num_tiles times, base advancing by DIM*DIM per tile (wraps);
//    addr_last only on final address of final tile; done once at end.
//  Undefined: port absent; exactly one DIM*DIM walk per start.
// STRUCTURE
//  - Shared package sa_pkg: FSM state encoding (IDLE/RUN/DONE), IDX_W=$clog2(DIM),
//    CNT_W helpers; reused by the activation and psum address generators.
//  - One sub-module sa_idx_counter2d: nested outer/inner counter with enable,
//    clear, and inner_wrap/last flags; instantiated once.
// TESTING
//  1 Reset: rst_n low mid-RUN -> addr_valid=0, busy=0, done=0 on the same edge.
//  2 DIM=3, base=0, transpose=1, ready=1 -> addrs 0,3,6,1,4,7,2,5,8; last on 8;
//    done one cycle after.
//  3 DIM=3, base=10, transpose=0 -> 10..18 in order; 9 handshakes in 9 cycles.
//  4 Backpressure: ready low 3 cycles at 4th address -> addr=1 held stable, no skip.
//  5 start pulsed during RUN and DONE -> ignored; walk count unchanged.
//  6 ADDR_W=6, base=60, transpose=0 -> 60..63,0..4 (wrap); with SA_WADDR_TILE_EN,
//    num_tiles=2, base=0 -> 18 addrs, second tile 9..17, single addr_last/done.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array address generators (weight, activation, psum).
package sa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sa_state_e;

    // Width of a 0..dim-1 index; never below one bit.
    function automatic int unsigned idx_w(input int unsigned dim);
        return (dim <= 2) ? 1 : $clog2(dim);
    endfunction

    // Width of a 0..dim*dim element count.
    function automatic int unsigned cnt_w(input int unsigned dim);
        return $clog2(dim * dim + 1);
    endfunction

endpackage

// File: rtl/sa_idx_counter2d.sv
// Nested outer/inner index counter over a DIMxDIM grid; exposes wrap flags only.
module sa_idx_counter2d
    import sa_pkg::*;
#(
    parameter int unsigned DIM = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic inner_wrap,
    output logic last
);

    localparam int unsigned IdxW = idx_w(DIM);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIM - 1);

    logic [IdxW-1:0] outer_q;
    logic [IdxW-1:0] inner_q;

    assign inner_wrap = (inner_q == IdxMax);
    assign last       = inner_wrap && (outer_q == IdxMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outer_q <= '0;
            inner_q <= '0;
        end else if (clr) begin
            outer_q <= '0;
            inner_q <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner_q <= '0;
                outer_q <= last ? '0 : outer_q + 1'b1;
            end else begin
                inner_q <= inner_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_weight_addr_gen.sv
// Weight-buffer address walker: row-major or column-major DIMxDIM sweep over valid/ready.
// Optional multi-tile repeat enabled by defining SA_WADDR_TILE_EN.
module sa_weight_addr_gen
    import sa_pkg::*;
#(
    parameter int unsigned DIM    = 3,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              transpose,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef SA_WADDR_TILE_EN
    input  logic [3:0]        num_tiles,
`endif
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] DimA = ADDR_W'(DIM);
    localparam logic [ADDR_W-1:0] One  = ADDR_W'(1);

    sa_state_e         state_q;
    logic              transpose_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] obase_q;
    logic [ADDR_W-1:0] inner_step;
    logic [ADDR_W-1:0] outer_step;
    logic [ADDR_W-1:0] next_tile_base;
    logic              launch;
    logic              hs;
    logic              cnt_wrap;
    logic              cnt_last;
    logic              final_tile;

    assign launch     = (state_q == StIdle) && start;
    assign hs         = addr_valid && addr_ready;
    assign inner_step = transpose_q ? DimA : One;
    assign outer_step = transpose_q ? One : DimA;
    assign addr       = addr_q;
    assign addr_last  = cnt_last && final_tile && addr_valid;

    sa_idx_counter2d #(
        .DIM (DIM)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (launch),
        .en         (hs),
        .inner_wrap (cnt_wrap),
        .last       (cnt_last)
    );

`ifdef SA_WADDR_TILE_EN
    localparam logic [ADDR_W-1:0] DimSq = ADDR_W'(DIM * DIM);

    logic [3:0]        tiles_q;
    logic [3:0]        tile_q;
    logic [ADDR_W-1:0] tbase_q;

    assign final_tile     = (tile_q == tiles_q - 4'd1);
    assign next_tile_base = tbase_q + DimSq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_q <= '0;
            tile_q  <= '0;
            tbase_q <= '0;
        end else if (launch) begin
            tiles_q <= (num_tiles == 4'd0) ? 4'd1 : num_tiles;
            tile_q  <= '0;
            tbase_q <= base_addr;
        end else if (hs && cnt_last && !final_tile) begin
            tile_q  <= tile_q + 4'd1;
            tbase_q <= next_tile_base;
        end
    end
`else
    assign final_tile     = 1'b1;
    assign next_tile_base = addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRun;
                        addr_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StRun: begin
                    if (hs && cnt_last && final_tile) begin
                        state_q    <= StDone;
                        addr_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Running address: inner steps add a stride, inner wraps reload from the outer base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            transpose_q <= 1'b0;
            addr_q      <= '0;
            obase_q     <= '0;
        end else if (launch) begin
            transpose_q <= transpose;
            addr_q      <= base_addr;
            obase_q     <= base_addr;
        end else if (hs) begin
            if (cnt_last) begin
                addr_q  <= next_tile_base;
                obase_q <= next_tile_base;
            end else if (cnt_wrap) begin
                addr_q  <= obase_q + outer_step;
                obase_q <= obase_q + outer_step;
            end else begin
                addr_q <= addr_q + inner_step;
            end
        end
    end

endmodule
